// File: rtl/pond_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pond_arb_pkg                                               |
// | Description : Shared types and default widths for the pond single-port   |
// |               access arbiter (write-buffer entry, port operation enum).  |
// | Ports       : none (package)                                             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package pond_arb_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_WBUF_DEPTH = 2;

  // One parked write, at the default geometry.
  typedef struct packed {
    logic [DEF_ADDR_WIDTH-1:0] addr;
    logic [DEF_DATA_WIDTH-1:0] data;
  } wbuf_entry_t;

  // What the single SRAM port does in a given cycle.
  typedef enum logic [1:0] {
    OP_IDLE   = 2'd0,
    OP_READ   = 2'd1,
    OP_DRAIN  = 2'd2,
    OP_BYPASS = 2'd3
  } port_op_t;

endpackage
`default_nettype wire

// File: rtl/pond_wbuf.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pond_wbuf                                                  |
// | Description : Circular write FIFO with occupancy counter and an          |
// |               associative youngest-match lookup on the stored addresses. |
// | Ports       : clk, rst (async, active-high), clear (sync discard),       |
// |               push/push_addr/push_data, pop, head_addr/head_data,        |
// |               empty/full, lu_addr -> lu_hit/lu_data                      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module pond_wbuf
  import pond_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DEPTH      = DEF_WBUF_DEPTH   // power of two, >= 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  push,
  input  logic [ADDR_WIDTH-1:0] push_addr,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [ADDR_WIDTH-1:0] head_addr,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic                  empty,
  output logic                  full,
  input  logic [ADDR_WIDTH-1:0] lu_addr,
  output logic                  lu_hit,
  output logic [DATA_WIDTH-1:0] lu_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [CNT_W-1:0]      count;
  logic [PTR_W-1:0]      idx;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  // Storage needs no reset: validity is carried entirely by count.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[tail] <= push_addr;
      data_mem[tail] <= push_data;
    end
  end

  assign head_addr = addr_mem[head];
  assign head_data = data_mem[head];
  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(DEPTH));

  // Walk from oldest to youngest; the last valid match wins, which yields
  // the youngest write to that address.
  always_comb begin
    lu_hit  = 1'b0;
    lu_data = '0;
    idx     = head;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PTR_W'(k);
      if ((CNT_W'(k) < count) && (addr_mem[idx] == lu_addr)) begin
        lu_hit  = 1'b1;
        lu_data = data_mem[idx];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pond_access_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pond_access_arbiter                                        |
// | Description : Shares one single-port pond SRAM between the write and the |
// |               read accessor. Reads own the port; colliding writes park   |
// |               in pond_wbuf and drain on the next read-free cycle.        |
// | Ports       : clk, rst (async, active-high), clk_en, flush,              |
// |               wr_req/wr_addr/wr_data, rd_req/rd_addr,                    |
// |               rd_valid/rd_data, mem_cen/mem_wen/mem_addr/mem_wdata,      |
// |               mem_rdata, wbuf_empty/wbuf_full, wr_overflow, raw_hazard   |
// | Config      : POND_ARB_RAW_FORWARD_EN - forward buffered data to reads   |
// |               (undefined: stale reads flagged on raw_hazard instead)     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module pond_access_arbiter
  import pond_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int WBUF_DEPTH = DEF_WBUF_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk_en,
  input  logic                  flush,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  mem_cen,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  wbuf_empty,
  output logic                  wbuf_full,
  output logic                  wr_overflow,
  output logic                  raw_hazard
);

  port_op_t              op;
  logic                  active;
  logic                  push;
  logic                  pop;
  logic                  overflow_set;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  wb_empty;
  logic                  wb_full;
  logic                  lu_hit;
  logic [DATA_WIDTH-1:0] lu_data;

  // rst is folded in so the port goes idle the instant reset asserts and
  // a drain in flight never reaches the macro.
  assign active = clk_en & ~flush & ~rst;

  always_comb begin
    op = OP_IDLE;
    if (active) begin
      if (rd_req)         op = OP_READ;
      else if (!wb_empty) op = OP_DRAIN;
      else if (wr_req)    op = OP_BYPASS;
    end
  end

  always_comb begin
    mem_cen   = 1'b0;
    mem_wen   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (op)
      OP_READ: begin
        mem_cen  = 1'b1;
        mem_addr = rd_addr;
      end
      OP_DRAIN: begin
        mem_cen   = 1'b1;
        mem_wen   = 1'b1;
        mem_addr  = head_addr;
        mem_wdata = head_data;
      end
      OP_BYPASS: begin
        mem_cen   = 1'b1;
        mem_wen   = 1'b1;
        mem_addr  = wr_addr;
        mem_wdata = wr_data;
      end
      default: ;
    endcase
  end

  // A full buffer still accepts a push when the head drains the same cycle.
  assign pop          = (op == OP_DRAIN);
  assign push         = active & wr_req & (op != OP_BYPASS) & (~wb_full | pop);
  assign overflow_set = active & wr_req & (op == OP_READ) & wb_full;

  pond_wbuf #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (WBUF_DEPTH)
  ) u_wbuf (
    .clk       (clk),
    .rst       (rst),
    .clear     (clk_en & flush),
    .push      (push),
    .push_addr (wr_addr),
    .push_data (wr_data),
    .pop       (pop),
    .head_addr (head_addr),
    .head_data (head_data),
    .empty     (wb_empty),
    .full      (wb_full),
    .lu_addr   (rd_addr),
    .lu_hit    (lu_hit),
    .lu_data   (lu_data)
  );

  assign wbuf_empty = wb_empty;
  assign wbuf_full  = wb_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid    <= 1'b0;
      wr_overflow <= 1'b0;
    end else if (clk_en) begin
      if (flush) begin
        rd_valid    <= 1'b0;
        wr_overflow <= 1'b0;
      end else begin
        rd_valid    <= rd_req;
        wr_overflow <= wr_overflow | overflow_set;
      end
    end
  end

`ifdef POND_ARB_RAW_FORWARD_EN
  // The lookup sees only entries pushed in earlier cycles, so a same-cycle
  // write to the read address is never forwarded.
  logic                  fwd_hit;
  logic [DATA_WIDTH-1:0] fwd_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_hit  <= 1'b0;
      fwd_data <= '0;
    end else if (clk_en) begin
      if (flush) begin
        fwd_hit  <= 1'b0;
        fwd_data <= '0;
      end else begin
        fwd_hit  <= rd_req & lu_hit;
        fwd_data <= lu_data;
      end
    end
  end

  assign rd_data    = rd_valid ? (fwd_hit ? fwd_data : mem_rdata) : '0;
  assign raw_hazard = 1'b0;
`else
  // Without forwarding the read returns the macro's (possibly stale) word;
  // a buffered match is only reported, aligned with rd_valid.
  logic                  stale;
  logic                  unused_lu_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stale <= 1'b0;
    end else if (clk_en) begin
      if (flush) stale <= 1'b0;
      else       stale <= rd_req & lu_hit;
    end
  end

  assign unused_lu_data = ^lu_data;
  assign rd_data        = rd_valid ? mem_rdata : '0;
  assign raw_hazard     = stale;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pond_access_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module      : tb_pond_access_arbiter                                     |
// | Description : Scoreboard bench for pond_access_arbiter. A queue-based    |
// |               reference model predicts SRAM port activity and read       |
// |               results; a negedge monitor compares them.                  |
// | Config      : honours POND_ARB_RAW_FORWARD_EN like the design            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_pond_access_arbiter;
  import pond_arb_pkg::*;

  localparam int DW    = DEF_DATA_WIDTH;
  localparam int AW    = DEF_ADDR_WIDTH;
  localparam int DEPTH = DEF_WBUF_DEPTH;
  localparam int WORDS = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          clk_en, flush, wr_req, rd_req;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data;
  logic          rd_valid, mem_cen, mem_wen, wbuf_empty, wbuf_full, wr_overflow, raw_hazard;
  logic [DW-1:0] rd_data, mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [AW-1:0] mem_addr;

  always #5 clk = ~clk;

  pond_access_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WBUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .flush(flush),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .wbuf_empty(wbuf_empty), .wbuf_full(wbuf_full),
    .wr_overflow(wr_overflow), .raw_hazard(raw_hazard)
  );

  // Behavioural single-port SRAM with 1-cycle read latency; output holds when idle.
  logic [DW-1:0] sram [WORDS];
  always @(posedge clk) begin
    if (mem_cen === 1'b1) begin
      if (mem_wen) sram[mem_addr] = mem_wdata;
      else         mem_rdata <= sram[mem_addr];
    end
  end

  typedef struct {
    logic          cen;
    logic          wen;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } port_exp_t;

  typedef struct {
    logic [DW-1:0] data;
    logic          hz;
  } rd_exp_t;

  port_exp_t     exp_port[$];
  rd_exp_t       exp_rd[$];
  rd_exp_t       last_rd;
  port_exp_t     mon_p;
  wbuf_entry_t   model_q[$];
  logic [DW-1:0] ref_mem [WORDS];
  logic          model_ovf;
  logic          model_rv;
  logic          ce_at_edge = 1'b0;
  int            total = 0;
  int            bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_valid"},    rd_valid,    0);
    check({tag, "_rd_data"},     rd_data,     0);
    check({tag, "_mem_cen"},     mem_cen,     0);
    check({tag, "_mem_wen"},     mem_wen,     0);
    check({tag, "_mem_addr"},    mem_addr,    0);
    check({tag, "_mem_wdata"},   mem_wdata,   0);
    check({tag, "_wbuf_empty"},  wbuf_empty,  1);
    check({tag, "_wbuf_full"},   wbuf_full,   0);
    check({tag, "_wr_overflow"}, wr_overflow, 0);
    check({tag, "_raw_hazard"},  raw_hazard,  0);
  endtask

  // One clock cycle: check registered flags against the model, drive the
  // inputs, advance the model and queue what the port/read should show.
  task automatic step(input logic ce, input logic fl, input logic wr,
                      input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input logic rd, input logic [AW-1:0] ra);
    port_exp_t   p;
    rd_exp_t     r;
    wbuf_entry_t e;
    @(posedge clk); #1;
    check("wbuf_empty",  wbuf_empty,  model_q.size() == 0);
    check("wbuf_full",   wbuf_full,   model_q.size() == DEPTH);
    check("wr_overflow", wr_overflow, model_ovf);
    check("rd_valid",    rd_valid,    model_rv);
    clk_en = ce; flush = fl; wr_req = wr; wr_addr = wa; wr_data = wd; rd_req = rd; rd_addr = ra;
    p = '{1'b0, 1'b0, '0, '0};
    if (ce && fl) begin
      model_q.delete();
      model_ovf = 1'b0;
      model_rv  = 1'b0;
    end else if (ce) begin
      model_rv = rd;
      if (rd) begin
        p = '{1'b1, 1'b0, ra, '0};
        r.data = ref_mem[ra];
        r.hz   = 1'b0;
        foreach (model_q[i]) begin
          if (model_q[i].addr == ra) begin
`ifdef POND_ARB_RAW_FORWARD_EN
            r.data = model_q[i].data;
`else
            r.hz = 1'b1;
`endif
          end
        end
        exp_rd.push_back(r);
        if (wr) begin
          if (model_q.size() < DEPTH) model_q.push_back('{addr: wa, data: wd});
          else                        model_ovf = 1'b1;
        end
      end else if (model_q.size() > 0) begin
        e = model_q.pop_front();
        p = '{1'b1, 1'b1, e.addr, e.data};
        ref_mem[e.addr] = e.data;
        if (wr) model_q.push_back('{addr: wa, data: wd});
      end else if (wr) begin
        p = '{1'b1, 1'b1, wa, wd};
        ref_mem[wa] = wd;
      end
    end
    exp_port.push_back(p);
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  // Assert rst in the middle of a drain cycle; the port must drop at once.
  task automatic reset_mid();
    @(posedge clk); #1;
    clk_en = 1'b1; flush = 1'b0; wr_req = 1'b1; wr_addr = 5'd9; wr_data = 16'hDEAD;
    rd_req = 1'b0; rd_addr = '0;
    #1;
    check("pre_reset_drain_cen", mem_cen, 1);
    #1 rst = 1'b1;
    #1 check_reset_outputs("mid_reset");
    model_q.delete();
    exp_rd.delete();
    exp_port.delete();
    model_ovf = 1'b0;
    model_rv  = 1'b0;
    last_rd   = '{'0, 1'b0};
    @(posedge clk); #1;
    check_reset_outputs("held_reset");
    wr_req = 1'b0;
    rst = 1'b0;
  endtask

  always @(posedge clk) ce_at_edge <= clk_en;

  // Monitor: compare port activity every cycle and read results whenever
  // the DUT presents rd_valid.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (exp_port.size() > 0) begin
        mon_p = exp_port.pop_front();
        check("port_cen", mem_cen, mon_p.cen);
        if (mon_p.cen) begin
          check("port_wen", mem_wen, mon_p.wen);
          check("port_addr", mem_addr, mon_p.addr);
          if (mon_p.wen) check("port_wdata", mem_wdata, mon_p.wdata);
        end
      end
      if (rd_valid === 1'b1) begin
        if (ce_at_edge) begin
          if (exp_rd.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rd_unexpected: rd_valid=1 required 0 (t=%0t)", $time);
          end else begin
            last_rd = exp_rd.pop_front();
          end
        end
        check("rd_data", rd_data, last_rd.data);
        check("raw_hazard", raw_hazard, last_rd.hz);
      end else begin
        check("rd_data_idle", rd_data, 0);
        check("raw_hazard_idle", raw_hazard, 0);
      end
    end
  end

  initial begin
    for (int i = 0; i < WORDS; i++) begin
      sram[i]    = DW'(16'hC000 + i);
      ref_mem[i] = DW'(16'hC000 + i);
    end
    rst = 1'b1; clk_en = 1'b0; flush = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_data = '0;
    model_ovf = 1'b0; model_rv = 1'b0; last_rd = '{'0, 1'b0};
    repeat (2) @(posedge clk);
    #1 check_reset_outputs("reset");
    rst = 1'b0;

    // Bypass write then read back.
    step(1, 0, 1, 5'd3, 16'hAAAA, 0, 5'd0);
    step(1, 0, 0, 5'd0, 16'h0,    1, 5'd3);
    idle();

    // Three colliding writes: two parked, third dropped; addr 3 keeps 0xAAAA.
    step(1, 0, 1, 5'd1, 16'h0011, 1, 5'd10);
    step(1, 0, 1, 5'd2, 16'h0022, 1, 5'd11);
    step(1, 0, 1, 5'd3, 16'h0033, 1, 5'd12);
    idle(); idle(); idle();
    step(1, 0, 0, 5'd0, 16'h0, 1, 5'd3);
    step(1, 0, 0, 5'd0, 16'h0, 1, 5'd1);
    idle();

    // Read of a still-buffered address (forwarded or flagged stale).
    step(1, 0, 1, 5'd7, 16'h5555, 1, 5'd0);
    step(1, 0, 0, 5'd0, 16'h0,    1, 5'd7);
    idle(); idle();

    // Full buffer, no read: drain and push together.
    step(1, 0, 1, 5'd8,  16'h8888, 1, 5'd0);
    step(1, 0, 1, 5'd9,  16'h9999, 1, 5'd0);
    step(1, 0, 1, 5'd10, 16'hA0A0, 0, 5'd0);
    idle(); idle(); idle();

    // Overflow, then flush with requests asserted: nothing commits.
    step(1, 0, 1, 5'd12, 16'h1212, 1, 5'd0);
    step(1, 0, 1, 5'd13, 16'h1313, 1, 5'd0);
    step(1, 0, 1, 5'd14, 16'h1414, 1, 5'd0);
    step(1, 1, 1, 5'd15, 16'h1515, 1, 5'd4);
    idle();
    step(1, 0, 0, 5'd0, 16'h0, 1, 5'd12);
    idle();

    // clk_en low with requests asserted: everything holds.
    step(1, 0, 0, 5'd0,  16'h0,    1, 5'd5);
    step(1, 0, 1, 5'd16, 16'h1616, 1, 5'd6);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 5'd17, 16'h1717, 1, 5'd16);
    idle(); idle();

    // Reset while draining: the parked writes are lost.
    step(1, 0, 1, 5'd20, 16'hBEEF, 1, 5'd0);
    step(1, 0, 1, 5'd21, 16'hCAFE, 1, 5'd0);
    reset_mid();
    step(1, 0, 0, 5'd0, 16'h0, 1, 5'd20);
    step(1, 0, 0, 5'd0, 16'h0, 1, 5'd21);
    step(1, 0, 0, 5'd0, 16'h0, 1, 5'd9);
    idle();

    // Randomised traffic on a narrow address range to provoke hazards.
    for (int n = 0; n < 800; n++) begin
      step($urandom_range(0, 9) != 0, $urandom_range(0, 39) == 0,
           1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom),
           1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)));
    end
    for (int i = 0; i < 4; i++) idle();
    for (int a = 0; a < 8; a++) step(1, 0, 0, '0, '0, 1, AW'(a));
    idle(); idle();
    @(posedge clk); #1;
    check("rd_outstanding", exp_rd.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pond_access_arbiter.md
# pond_access_arbiter

Shares one single-port pond SRAM between the pond's write accessor and read accessor. Reads always own the port in the cycle they are scheduled. Writes that collide with a read are parked in a small write buffer and drained on the next read-free cycle. The block sits between the accessor valid/address outputs and the memory macro; it replaces the dual-port storage assumption with a single-port macro plus arbitration.

## Interface
Parameters:
- DATA_WIDTH, 16, word width
- ADDR_WIDTH, 5, memory address width (32 words)
- WBUF_DEPTH, 2, write-buffer entries; power of two, ≥2

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- clk_en  in  1  global clock enable; when low, all state holds and the port is idle
- flush  in  1  synchronous clear (qualified by clk_en)
- wr_req  in  1  write accessor valid
- wr_addr  in  ADDR_WIDTH  write address
- wr_data  in  DATA_WIDTH  write data
- rd_req  in  1  read accessor valid
- rd_addr  in  ADDR_WIDTH  read address
- rd_valid  out  1  read data valid, one cycle after rd_req
- rd_data  out  DATA_WIDTH  read data; 0 when rd_valid=0
- mem_cen  out  1  SRAM access enable
- mem_wen  out  1  SRAM write enable (meaningful only when mem_cen=1)
- mem_addr  out  ADDR_WIDTH  SRAM address
- mem_wdata  out  DATA_WIDTH  SRAM write data
- mem_rdata  in  DATA_WIDTH  SRAM read data, one cycle after a read access
- wbuf_empty  out  1  write buffer empty
- wbuf_full  out  1  write buffer full
- wr_overflow  out  1  sticky; set when a write is dropped
- raw_hazard  out  1  one-cycle pulse on a stale read (forwarding off only)

## Operation
Port op is decided combinationally each cycle with clk_en=1 and flush=0, in priority order:
- READ: rd_req=1 → mem_cen=1, mem_wen=0, mem_addr=rd_addr.
- DRAIN: no rd_req and wbuf not empty → write the buffer head to the SRAM and pop it.
- BYPASS: no rd_req, wbuf empty, wr_req=1 → write wr_addr/wr_data directly; nothing is buffered.
- IDLE: none of the above → mem_cen=0.

Write acceptance:
- wr_req with any op other than BYPASS pushes to the buffer tail.
- When DRAIN and push happen in the same cycle, both occur; occupancy is unchanged.
- If wr_req=1, the op is READ and the buffer is full: the write is dropped and wr_overflow is set.

Ordering and visibility:
- The buffer is strictly FIFO, so writes commit to memory in arrival order.
- A read observes only writes from earlier cycles. A same-cycle wr_req to the same address is never visible to that read.

Flush:
- Discards all buffered writes without committing them.
- Clears rd_valid, the forwarding state and wr_overflow.
- The port is IDLE in the flush cycle.

Reset values: rd_valid=0, rd_data=0, mem_cen=0, mem_wen=0, mem_addr=0, mem_wdata=0, wbuf_empty=1, wbuf_full=0, wr_overflow=0, raw_hazard=0.

## Timing
- mem_* outputs are combinational from the request inputs and buffer state, in the same cycle.
- Read latency is exactly 1. rd_valid is registered from rd_req. rd_data selects the registered forwarded word on a forward hit, otherwise mem_rdata.
- Write commit latency: 0 cycles for BYPASS; otherwise the number of cycles until the entry reaches the head and a read-free cycle occurs.
- wbuf_full/wbuf_empty are registered occupancy flags and update the cycle after a push or pop.
- With clk_en=0: no register changes and mem_cen=0. rd_valid and rd_data hold their values.
- Reset mid-drain: buffered writes are lost; no partial SRAM write occurs after rst is asserted.

## Configuration
Macro: POND_ARB_RAW_FORWARD_EN.

Defined:
- A read whose address matches a buffered entry returns the youngest matching entry's data, registered and presented with the normal 1-cycle latency.
- The SRAM read still occurs.
- raw_hazard is tied to 0.

Undefined:
- No address comparison is made against buffered entries for forwarding; rd_data is always mem_rdata, which may be stale.
- A match on any buffered entry pulses raw_hazard in the cycle rd_valid is asserted.

## Structure
- Package pond_arb_pkg holds:
  - typedef wbuf_entry_t {addr, data}
  - enum port_op_t {OP_IDLE, OP_READ, OP_DRAIN, OP_BYPASS}
  - default width constants
- Sub-module pond_wbuf: circular FIFO with head/tail pointers, occupancy counter, push/pop, and an associative youngest-match lookup port (addr in → hit, data out).
- The top level holds only the op decode, forward and rd_valid registers, and the overflow flag.

## Test plan
- Bypass: wr_req addr 3 data 0xAAAA with no read; read addr 3 next cycle → mem_wen=1 in the first cycle, then rd_valid=1 and rd_data=0xAAAA one cycle after the read.
- Collision: wr_req and rd_req together for 3 cycles (writes to addr 1,2,3 with data 0x11,0x22,0x33), then idle → 2 entries buffered, third write dropped, wr_overflow=1; drains commit addr 1 then 2; addr 3 is never written.
- Forwarding (macro on): buffer 0x5555 to addr 7 while a read runs, then read addr 7 before the drain → rd_data=0x5555, raw_hazard=0. Macro off → old memory value is returned and raw_hazard pulses.
- Simultaneous drain and push with a full buffer and rd_req=0 → occupancy stays at 2, wr_overflow stays 0, FIFO order preserved.
- Flush with 2 entries buffered → wbuf_empty=1 the next cycle; no SRAM writes issued; wr_overflow cleared.
- clk_en=0 for 4 cycles with requests asserted → mem_cen=0, buffer and flags unchanged; assert rst mid-sequence → all outputs return to their reset values immediately.
